// File: rtl/gcd_ctrl.sv
// Euclid GCD sequencer driving a shared shift-subtract divider.
// Each remainder step is one divider launch; a stalled divider ends the operation with err.
`timescale 1ns/1ps

module gcd_ctrl #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] gcd_out,
    output logic [3:0] iter_out,
    output logic       err,
    output logic       div_load,
    output logic [7:0] div_dvd,
    output logic [7:0] div_dvn,
    input  logic [7:0] div_r,
    input  logic       div_complete
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    // Last WAIT cycle value of wcnt before its increment reaches WAIT_MAX
    localparam logic [3:0] W_LAST = 4'(WAIT_MAX - 1);

    state_t     r_state;
    state_t     w_state_nxt;

    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [3:0] r_iter;
    logic [3:0] r_wcnt;
    logic [7:0] r_gcd;
    logic       r_err;
    logic       r_busy;
    logic       r_done;
    logic       r_load;

    logic [7:0] w_a;
    logic [7:0] w_b;
    logic [3:0] w_iter;
    logic [3:0] w_wcnt;
    logic [7:0] w_gcd;
    logic       w_err;
    logic       w_busy;
    logic       w_done;
    logic       w_load;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_iter  <= '0;
            r_wcnt  <= '0;
            r_gcd   <= '0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_load  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_a     <= w_a;
            r_b     <= w_b;
            r_iter  <= w_iter;
            r_wcnt  <= w_wcnt;
            r_gcd   <= w_gcd;
            r_err   <= w_err;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_load  <= w_load;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_a         = r_a;
        w_b         = r_b;
        w_iter      = r_iter;
        w_wcnt      = r_wcnt;
        w_gcd       = r_gcd;
        w_err       = r_err;
        w_busy      = r_busy;
        w_done      = 1'b0;
        w_load      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_a         = a_in;
                    w_b         = b_in;
                    w_iter      = '0;
                    w_err       = 1'b0;
                    w_busy      = 1'b1;
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: begin
                if (r_b == 8'd0) begin
                    w_gcd       = r_a;
                    w_done      = 1'b1;
                    w_state_nxt = S_DONE;
                end else begin
                    w_load      = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_wcnt      = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // Remainder feeds back as the new divisor; the old divisor becomes the dividend
                if (div_complete) begin
                    w_a         = r_b;
                    w_b         = div_r;
                    w_iter      = (r_iter == 4'hF) ? r_iter : r_iter + 4'd1;
                    w_state_nxt = S_CHECK;
                end else begin
                    w_wcnt = r_wcnt + 4'd1;
                    if (r_wcnt == W_LAST) begin
                        w_err       = 1'b1;
                        w_gcd       = '0;
                        w_done      = 1'b1;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                w_busy      = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign gcd_out  = r_gcd;
    assign iter_out = r_iter;
    assign err      = r_err;
    assign div_load = r_load;
    assign div_dvd  = r_a;
    assign div_dvn  = r_b;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Randomized self-checking bench for gcd_ctrl with a behavioural divider and a Euclid reference model.
`timescale 1ns/1ps

module tb_gcd_ctrl;

    localparam int unsigned WAIT_MAX = 15;

    logic       clk_in = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] a_in;
    logic [7:0] b_in;
    logic       busy;
    logic       done;
    logic [7:0] gcd_out;
    logic [3:0] iter_out;
    logic       err;
    logic       div_load;
    logic [7:0] div_dvd;
    logic [7:0] div_dvn;
    logic [7:0] div_r;
    logic       div_complete;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    logic [7:0]  prev_gcd = 8'd0;
    bit          stall = 1'b0;

    // Behavioural divider: counts d+1 negedges after a load, remainder via plain arithmetic
    int unsigned div_cnt = 0;
    logic [7:0]  div_rem = 8'd0;

    gcd_ctrl #(.WAIT_MAX(WAIT_MAX)) dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .start       (start),
        .a_in        (a_in),
        .b_in        (b_in),
        .busy        (busy),
        .done        (done),
        .gcd_out     (gcd_out),
        .iter_out    (iter_out),
        .err         (err),
        .div_load    (div_load),
        .div_dvd     (div_dvd),
        .div_dvn     (div_dvn),
        .div_r       (div_r),
        .div_complete(div_complete)
    );

    always #5 clk_in = ~clk_in;

    function automatic int unsigned msb_idx(input logic [7:0] v);
        int unsigned m = 0;
        for (int unsigned i = 0; i < 8; i++) if (v[i]) m = i;
        return m;
    endfunction

    always @(negedge clk_in) begin
        if (div_load) begin
            div_cnt <= 8 - msb_idx(div_dvn);
            div_rem <= (div_dvn == 8'd0) ? 8'd0 : div_dvd % div_dvn;
        end else if (div_cnt != 0) begin
            div_cnt <= div_cnt - 1;
        end
    end

    assign div_complete = !stall && (div_cnt == 0);
    assign div_r        = div_rem;

    // Reference: Euclid with the per-step cost CHECK+LOAD+WAIT = d+3 cycles
    logic [7:0]  exp_ld_a[$];
    logic [7:0]  exp_ld_b[$];

    task automatic model(input logic [7:0] a, input logic [7:0] b,
                         output logic [7:0] g, output logic [3:0] it,
                         output int unsigned done_cyc);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned t;
        int unsigned n = 0;
        done_cyc = 2;
        exp_ld_a.delete();
        exp_ld_b.delete();
        while (y != 0) begin
            exp_ld_a.push_back(8'(x));
            exp_ld_b.push_back(8'(y));
            done_cyc += (7 - msb_idx(8'(y))) + 3;
            t = x % y;
            x = y;
            y = t;
            n++;
        end
        g  = 8'(x);
        it = (n > 15) ? 4'd15 : 4'(n);
    endtask

    task automatic run_transaction(input logic [7:0] a, input logic [7:0] b,
                                   input bit hold_div, input bit inject);
        logic [7:0]  eg;
        logic [3:0]  eit;
        logic        eerr;
        int unsigned edone;
        int unsigned eloads;
        int unsigned loads = 0;
        int unsigned k = 1;
        bit          seen = 1'b0;

        model(a, b, eg, eit, edone);
        eerr   = 1'b0;
        eloads = exp_ld_a.size();
        if (hold_div && b != 8'd0) begin
            eg     = 8'd0;
            eit    = 4'd0;
            eerr   = 1'b1;
            edone  = 2 + WAIT_MAX + 1;
            eloads = 1;
        end
        stall = hold_div;

        a_in  = a;
        b_in  = b;
        start = 1'b1;
        @(posedge clk_in);
        #1;
        start = 1'b0;
        while (!seen && k <= 300) begin
            if (k == 1) begin
                n_cmp += 3;
                if (err !== 1'b0) begin
                    n_err++; $display("FAIL err_cleared a=%0d b=%0d: got %0b expected 0", a, b, err);
                end
                if (iter_out !== 4'd0) begin
                    n_err++; $display("FAIL iter_cleared a=%0d b=%0d: got %0d expected 0", a, b, iter_out);
                end
                if (gcd_out !== prev_gcd) begin
                    n_err++; $display("FAIL gcd_held a=%0d b=%0d: got %0d expected %0d", a, b, gcd_out, prev_gcd);
                end
            end
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++; $display("FAIL busy_high a=%0d b=%0d cycle %0d: got %0b expected 1", a, b, k, busy);
            end
            if (div_load === 1'b1) begin
                n_cmp++;
                if (div_dvn === 8'd0) begin
                    n_err++; $display("FAIL load_dvn_nonzero a=%0d b=%0d cycle %0d: got 0 expected nonzero", a, b, k);
                end
                if (loads < eloads) begin
                    n_cmp++;
                    if (div_dvd !== exp_ld_a[loads] || div_dvn !== exp_ld_b[loads]) begin
                        n_err++;
                        $display("FAIL load_operands a=%0d b=%0d load %0d: got %0d/%0d expected %0d/%0d",
                                 a, b, loads, div_dvd, div_dvn, exp_ld_a[loads], exp_ld_b[loads]);
                    end
                end
                loads++;
            end
            if (done === 1'b1) begin
                seen = 1'b1;
                n_cmp += 4;
                if (k != edone) begin
                    n_err++; $display("FAIL done_cycle a=%0d b=%0d: got %0d expected %0d", a, b, k, edone);
                end
                if (gcd_out !== eg) begin
                    n_err++; $display("FAIL gcd a=%0d b=%0d: got %0d expected %0d", a, b, gcd_out, eg);
                end
                if (iter_out !== eit) begin
                    n_err++; $display("FAIL iter a=%0d b=%0d: got %0d expected %0d", a, b, iter_out, eit);
                end
                if (err !== eerr) begin
                    n_err++; $display("FAIL err a=%0d b=%0d: got %0b expected %0b", a, b, err, eerr);
                end
            end else begin
                start = 1'b0;
                if (inject && k + 1 < edone && $urandom_range(0, 2) == 0) begin
                    start = 1'b1;
                    a_in  = 8'($urandom_range(0, 255));
                    b_in  = 8'($urandom_range(0, 255));
                end
                @(posedge clk_in);
                #1;
                k++;
            end
        end
        start = 1'b0;
        if (!seen) begin
            n_cmp++; n_err++;
            $display("FAIL done_timeout a=%0d b=%0d: got no done expected cycle %0d", a, b, edone);
        end
        n_cmp++;
        if (loads != eloads) begin
            n_err++; $display("FAIL load_count a=%0d b=%0d: got %0d expected %0d", a, b, loads, eloads);
        end
        @(posedge clk_in);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_err++; $display("FAIL idle_after_done a=%0d b=%0d: got busy=%0b done=%0b expected 0 0", a, b, busy, done);
        end
        prev_gcd = eg;
        stall    = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk_in);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a_in  = 8'd0;
        b_in  = 8'd0;
        repeat (3) @(posedge clk_in);
        #1;
        n_cmp++;
        if ({busy, done, err, div_load, gcd_out, iter_out, div_dvd, div_dvn} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got %h expected 0",
                              {busy, done, err, div_load, gcd_out, iter_out, div_dvd, div_dvn});
        end
        rst_n = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    task automatic test_zero_operand();
        run_transaction(8'd5, 8'd0, 1'b0, 1'b0);
        run_transaction(8'd0, 8'd0, 1'b0, 1'b0);
    endtask

    task automatic test_known_pairs();
        run_transaction(8'd12, 8'd8, 1'b0, 1'b0);
        run_transaction(8'd0, 8'd7, 1'b0, 1'b0);
        run_transaction(8'd8, 8'd12, 1'b0, 1'b0);
        run_transaction(8'd144, 8'd233, 1'b0, 1'b0);
    endtask

    task automatic test_start_while_busy();
        run_transaction(8'd233, 8'd144, 1'b0, 1'b1);
        run_transaction(8'd255, 8'd1, 1'b0, 1'b1);
    endtask

    task automatic test_timeout();
        run_transaction(8'd100, 8'd7, 1'b1, 1'b0);
        run_transaction(8'd100, 8'd7, 1'b0, 1'b0);
        run_transaction(8'd9, 8'd128, 1'b1, 1'b0);
        run_transaction(8'd9, 8'd128, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_wait();
        a_in  = 8'd12;
        b_in  = 8'd8;
        start = 1'b1;
        @(posedge clk_in);
        #1;
        start = 1'b0;
        repeat (11) @(posedge clk_in);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, err, div_load, gcd_out, iter_out, div_dvd, div_dvn} !== '0) begin
            n_err++; $display("FAIL async_reset_outputs: got %h expected 0",
                              {busy, done, err, div_load, gcd_out, iter_out, div_dvd, div_dvn});
        end
        @(posedge clk_in);
        #1;
        rst_n    = 1'b1;
        prev_gcd = 8'd0;
        @(posedge clk_in);
        #1;
        n_cmp++;
        if (busy !== 1'b0) begin
            n_err++; $display("FAIL idle_after_reset: got busy=%0b expected 0", busy);
        end
        run_transaction(8'd48, 8'd18, 1'b0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] a;
        logic [7:0] b;
        for (int i = 0; i < 30; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 9) == 0) b = 8'd0;
            if ($urandom_range(0, 9) == 0) a = 8'd0;
            run_transaction(a, b, ($urandom_range(0, 11) == 0), ($urandom_range(0, 1) == 1));
        end
    endtask

    initial begin
        test_reset();
        test_zero_operand();
        test_known_pairs();
        test_start_while_busy();
        test_timeout();
        test_reset_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
